// File: rtl/tam_bank_memory.sv
// Tilemap attribute memory: double-buffered bank store for the tilemap renderer.
// The renderer reads the active bank through a registered port. The CPU writes
// the back bank with byte enables. A fill engine clears or initialises the back
// bank. Bank swaps are requested at any time and committed on frame_sync.
module tam_bank_memory #(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 1200,
    parameter int ADDR_W     = 11,
    parameter int DOUBLE_BUF = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_rd_en,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_W-1:0]     o_rd_data,
    output logic                  o_rd_valid,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0]     i_wr_data,
    input  logic [DATA_W/8-1:0]   i_wr_be,
    output logic                  o_wr_reject,
    input  logic                  i_swap_req,
    input  logic                  i_frame_sync,
    output logic                  o_swap_pending,
    output logic                  o_swap_done,
    output logic                  o_active_bank,
    input  logic                  i_fill_start,
    input  logic [DATA_W-1:0]     i_fill_value,
    output logic                  o_busy
);
    localparam int              BE_W     = DATA_W / 8;
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_IDLE, ST_FILL} state_t;

    // Two banks are always declared; with DOUBLE_BUF=0 bank 1 is never addressed.
    logic [DATA_W-1:0] r_mem [0:1][0:DEPTH-1];

    state_t            r_state;
    logic              r_busy;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_fill_val;
    logic              r_active_bank;
    logic              r_swap_pending;
    logic              r_swap_done;
    logic              r_wr_reject;
    logic [DATA_W-1:0] r_rd_data_p1;
    logic              r_rd_vld_p1;

    logic w_back_bank;
    logic w_rd_in_range;
    logic w_wr_in_range;
    logic w_wr_ok;
    logic w_swap_commit;

    assign w_back_bank   = (DOUBLE_BUF != 0) ? ~r_active_bank : 1'b0;
    assign w_rd_in_range = ({1'b0, i_rd_addr} < LP_DEPTH);
    assign w_wr_in_range = ({1'b0, i_wr_addr} < LP_DEPTH);
    assign w_wr_ok       = i_wr_en && !r_busy && w_wr_in_range;
    // A swap request arriving together with frame_sync commits in that same edge.
    assign w_swap_commit = (DOUBLE_BUF != 0) && i_frame_sync
                           && (r_swap_pending || i_swap_req) && !r_busy;

    // Renderer read port: one-cycle latency, holds data when idle, zero out of range.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_data_p1 <= '0;
            r_rd_vld_p1  <= 1'b0;
        end else begin
            r_rd_vld_p1 <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data_p1 <= w_rd_in_range ? r_mem[r_active_bank][i_rd_addr] : '0;
            end
        end
    end

    // Bank storage: the fill engine owns the back bank while running, otherwise CPU byte writes.
    always_ff @(posedge i_clk) begin
        if (r_state == ST_FILL) begin
            r_mem[w_back_bank][r_cnt] <= r_fill_val;
        end else if (w_wr_ok) begin
            for (int b = 0; b < BE_W; b++) begin
                if (i_wr_be[b]) begin
                    r_mem[w_back_bank][i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Dropped CPU writes (fill running or address past the bank) are flagged one cycle later.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_reject <= 1'b0;
        end else begin
            r_wr_reject <= i_wr_en && (r_busy || !w_wr_in_range);
        end
    end

    // Fill engine: latch the fill word, then sweep the back bank one word per cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_cnt      <= '0;
            r_fill_val <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_fill_start) begin
                        r_state    <= ST_FILL;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_fill_val <= i_fill_value;
                    end
                end
                ST_FILL: begin
                    if (r_cnt == LP_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Swap control: hold the request until a frame_sync arrives with the fill engine idle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_active_bank  <= 1'b0;
            r_swap_pending <= 1'b0;
            r_swap_done    <= 1'b0;
        end else if (DOUBLE_BUF != 0) begin
            r_swap_done <= w_swap_commit;
            if (w_swap_commit) begin
                r_active_bank  <= ~r_active_bank;
                r_swap_pending <= 1'b0;
            end else if (i_swap_req) begin
                r_swap_pending <= 1'b1;
            end
        end
    end

    assign o_rd_data      = r_rd_data_p1;
    assign o_rd_valid     = r_rd_vld_p1;
    assign o_wr_reject    = r_wr_reject;
    assign o_swap_pending = r_swap_pending;
    assign o_swap_done    = r_swap_done;
    assign o_active_bank  = r_active_bank;
    assign o_busy         = r_busy;

endmodule
